// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the memory-stage result for writeback,
// drives the register-file write port (also the EX bypass source) and owns
// the 64-bit retired-instruction counter (minstret/minstreth).
module mem_wb_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc4_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] data_or_alu_i,
    input  logic [31:0] csr_data_i,
    input  logic [11:0] csr_addr_i,
    input  logic [3:0]  trap_code_i,
    input  logic        is_trap_i,
    input  logic        is_rs0_i,
    input  logic        valid_i,
    input  logic        reg_we_i,
    input  logic        wb_sel_i,
    input  logic        stall_mem_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic        instret_lo_we_i,
    input  logic        instret_hi_we_i,
    input  logic [31:0] instret_wdata_i,
    output logic [31:0] pc4_o,
    output logic [31:0] pc_o,
    output logic [31:0] csr_data_o,
    output logic [4:0]  rd_o,
    output logic [11:0] csr_addr_o,
    output logic [3:0]  trap_code_o,
    output logic        is_trap_o,
    output logic        is_rs0_o,
    output logic        valid_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [63:0] instret_o
);

    logic [31:0] r_pc4;
    logic [31:0] r_pc;
    logic [31:0] r_csr_data;
    logic [4:0]  r_rd;
    logic [11:0] r_csr_addr;
    logic [3:0]  r_trap_code;
    logic        r_is_trap;
    logic        r_is_rs0;
    logic        r_valid;
    logic        r_rf_we;
    logic [31:0] r_rf_wdata;
    logic [63:0] r_instret;

    logic        w_kill;
    logic        w_rf_we_next;
    logic [31:0] w_rf_wdata_next;
    logic        w_retire;

    // Flush always kills; a MEM stall only inserts a bubble when WB is not held
    // Writes to x0 and trapping instructions never reach the register file
    // An instruction retires in the cycle it leaves WB without being held
    always_comb begin
        w_kill          = flush_i | (stall_mem_i & ~hold_i);
        w_rf_we_next    = valid_i & reg_we_i & ~is_trap_i & (rd_i != 5'd0);
        w_rf_wdata_next = wb_sel_i ? pc4_i : data_or_alu_i;
        w_retire        = r_valid & ~r_is_trap & ~hold_i;
    end

    // Status bits: cleared on flush/bubble, frozen on hold, else captured
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_is_trap <= 1'b0;
        end else if (w_kill) begin
            r_valid   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_is_trap <= 1'b0;
        end else if (!hold_i) begin
            r_valid   <= valid_i;
            r_rf_we   <= w_rf_we_next;
            r_is_trap <= valid_i & is_trap_i;
        end
    end

    // Payload is only loaded on a real capture; a killed slot keeps stale data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc4       <= 32'd0;
            r_pc        <= 32'd0;
            r_csr_data  <= 32'd0;
            r_rd        <= 5'd0;
            r_csr_addr  <= 12'd0;
            r_trap_code <= 4'd0;
            r_is_rs0    <= 1'b0;
            r_rf_wdata  <= 32'd0;
        end else if (!w_kill && !hold_i) begin
            r_pc4       <= pc4_i;
            r_pc        <= pc_i;
            r_csr_data  <= csr_data_i;
            r_rd        <= rd_i;
            r_csr_addr  <= csr_addr_i;
            r_trap_code <= trap_code_i;
            r_is_rs0    <= is_rs0_i;
            r_rf_wdata  <= w_rf_wdata_next;
        end
    end

    // CSR writes to either half take precedence over the retire increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instret <= 64'd0;
        end else if (instret_lo_we_i || instret_hi_we_i) begin
            if (instret_lo_we_i) r_instret[31:0]  <= instret_wdata_i;
            if (instret_hi_we_i) r_instret[63:32] <= instret_wdata_i;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign pc4_o       = r_pc4;
    assign pc_o        = r_pc;
    assign csr_data_o  = r_csr_data;
    assign rd_o        = r_rd;
    assign csr_addr_o  = r_csr_addr;
    assign trap_code_o = r_trap_code;
    assign is_trap_o   = r_is_trap;
    assign is_rs0_o    = r_is_rs0;
    assign valid_o     = r_valid;
    assign rf_we_o     = r_rf_we;
    assign rf_waddr_o  = r_rd;
    assign rf_wdata_o  = r_rf_wdata;
    assign instret_o   = r_instret;

endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

MEM/WB pipeline boundary of the core: registers the result of the memory stage (ALU or load data, PC, trap information, CSR payload) and presents it to writeback, the register file, the CSR unit and the EX-stage bypass network. Turns a memory-stage stall into WB bubbles, honours pipeline flush and downstream hold, and owns the 64-bit retired-instruction counter (minstret/minstreth). Sits directly downstream of the MEM stage.

## Interface
- No parameters.
- clk_i  in  1  core clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- pc4_i, pc_i  in  32  PC+4 and PC from MEM
- rd_i  in  5  destination register address
- data_or_alu_i  in  32  load data or ALU result from MEM
- csr_data_i  in  32  CSR write payload; csr_addr_i  in  12  CSR address
- trap_code_i  in  4  exception code; is_trap_i  in  1  trap flag; is_rs0_i  in  1  rs1==x0 flag (for CSR set/clear)
- valid_i  in  1  MEM holds a real instruction
- reg_we_i  in  1  instruction writes rd; wb_sel_i  in  1  0: data_or_alu_i, 1: pc4_i
- stall_mem_i  in  1  MEM access not finished this cycle
- hold_i  in  1  downstream (CSR/trap unit) stall: freeze this register
- flush_i  in  1  kill the instruction entering WB
- instret_lo_we_i, instret_hi_we_i  in  1  CSR write strobes for minstret / minstreth; instret_wdata_i  in  32  write data
- pc4_o, pc_o, csr_data_o  out  32; rd_o  out  5; csr_addr_o  out  12; trap_code_o  out  4; is_trap_o, is_rs0_o  out  1  registered payload
- valid_o  out  1  WB holds a real instruction
- rf_we_o  out  1; rf_waddr_o  out  5; rf_wdata_o  out  32  register-file write port, also the EX bypass source
- instret_o  out  64  retired-instruction count

## Operation
- Reset (rst_ni low, immediate): every output and register 0, including valid_o, rf_we_o, instret_o.
- Per rising edge, priority order:
  - flush_i: valid_o←0, rf_we_o←0, is_trap_o←0; other payload don't-care (held).
  - else hold_i: all registers keep their value.
  - else stall_mem_i: bubble — valid_o←0, rf_we_o←0, is_trap_o←0.
  - else capture: all payload ←inputs; valid_o←valid_i; rf_waddr_o←rd_i; rf_wdata_o←wb_sel_i ? pc4_i : data_or_alu_i; rf_we_o←valid_i & reg_we_i & ~is_trap_i & (rd_i≠0); is_trap_o←valid_i & is_trap_i.
- rf_we_o never asserts for rd=x0 or a trapping instruction. While held, rf_we_o stays high; repeated writes of the same value are permitted and harmless.
- Retire event: valid_o & ~is_trap_o & ~hold_i in the current cycle (instruction leaves WB exactly once).
- instret update per edge (not during reset):
  - instret_lo_we_i: instret_o[31:0]←instret_wdata_i, upper half unchanged, no increment this cycle.
  - else instret_hi_we_i: instret_o[63:32]←instret_wdata_i, lower half unchanged, no increment.
  - both strobes together: both halves written, no increment.
  - else retire: instret_o←instret_o+1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF → 0; carry from low to high half).

## Timing
- Latency 1 cycle: MEM values sampled on edge N appear on outputs after edge N.
- A stall_mem_i burst of k cycles produces exactly k bubble cycles; the instruction appears the cycle after stall_mem_i drops.
- flush_i and stall_mem_i together: flush wins (bubble either way). flush_i and hold_i together: flush wins; the held instruction is dropped and not counted.
- hold_i with stall_mem_i: hold wins; current WB contents preserved.
- instret_o reflects a retire one edge after the retire cycle.
- Reset asserted mid-burst or mid-hold clears everything asynchronously; first capture is on the first edge after rst_ni rises.

## Test plan
- Reset: drive random inputs, pulse rst_ni low between edges → all outputs 0 immediately; after release, first valid capture pc_i=0x0000_0010 appears on pc_o next cycle.
- ALU writeback: valid_i=1, reg_we_i=1, rd_i=5, data_or_alu_i=0xDEAD_BEEF, wb_sel_i=0 → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEAD_BEEF; repeat with rd_i=0 → rf_we_o=0; wb_sel_i=1, pc4_i=0x104 → rf_wdata_o=0x104.
- Stall: stall_mem_i high 3 cycles with a load in MEM → valid_o=0, rf_we_o=0 for 3 cycles, load result captured the cycle after release; instret increments by exactly 1.
- Trap/flush: is_trap_i=1, trap_code_i=4 → is_trap_o=1, trap_code_o=4, rf_we_o=0, instret unchanged; flush_i together with valid_i=1 → valid_o=0.
- Hold: hold_i high 4 cycles with a valid instruction in WB → outputs frozen, instret increments once (on the cycle hold_i drops), not 5 times.
- Counter: instret_lo_we_i/instret_hi_we_i writing 0xFFFF_FFFF to both halves, then one retire → instret_o=0; lo write coincident with a retire → low=wdata, no increment.
